// File: rtl/register_file_pkg.sv
// Shared types and constants for the register file slice.
// Package: rv_pkg
//   XLEN/TAG_W/NREG : default datapath widths and register count
//   REG_ZERO        : index of the hardwired-zero register
//   tag_t/word_t    : ROB tag and data word types
package rv_pkg;
  localparam int XLEN  = 32;
  localparam int TAG_W = 6;
  localparam int NREG  = 32;
  localparam int REG_W = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [XLEN-1:0]  word_t;
  typedef logic [REG_W-1:0] reg_idx_t;
endpackage

// File: rtl/register_file_if.sv
// Bus between issue unit / ROB and the register file.
//   control : rdy (global enable), flush (misprediction)
//   rename  : issue_valid, issue_rd, issue_rob_index
//   read    : rs1/rs2 in; rsN_busy/rsN_tag/rsN_value out
//   commit  : rf_valid, rf_index, rf_rd, rf_value
// master = issue/ROB side, slave = register file.
interface register_file_if #(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int TAG_W = rv_pkg::TAG_W
);
  logic             rdy;
  logic             flush;
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic [TAG_W-1:0] issue_rob_index;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic             rs1_busy;
  logic [TAG_W-1:0] rs1_tag;
  logic [XLEN-1:0]  rs1_value;
  logic             rs2_busy;
  logic [TAG_W-1:0] rs2_tag;
  logic [XLEN-1:0]  rs2_value;
  logic             rf_valid;
  logic [TAG_W-1:0] rf_index;
  logic [4:0]       rf_rd;
  logic [XLEN-1:0]  rf_value;

  modport master (
    output rdy, flush, issue_valid, issue_rd, issue_rob_index, rs1, rs2,
           rf_valid, rf_index, rf_rd, rf_value,
    input  rs1_busy, rs1_tag, rs1_value, rs2_busy, rs2_tag, rs2_value
  );

  modport slave (
    input  rdy, flush, issue_valid, issue_rd, issue_rob_index, rs1, rs2,
           rf_valid, rf_index, rf_rd, rf_value,
    output rs1_busy, rs1_tag, rs1_value, rs2_busy, rs2_tag, rs2_value
  );
endinterface

// File: rtl/register_file_read_port.sv
// One combinational read port of the register file.
// Selects busy/tag/value for index rs, forces x0 to all-zero, and with
// RF_COMMIT_BYPASS_EN defined forwards a same-cycle commit to the reader.
// Ports:
//   rs                      : source register index
//   busy_q/tag_q/value_q    : full registered state
//   rf_valid/rf_index/rf_rd/rf_value : commit bus (bypass build only)
//   busy/tag/value          : read result
// Macro: RF_COMMIT_BYPASS_EN
module rf_read_port
  import rv_pkg::*;
#(
  parameter int NREG  = rv_pkg::NREG,
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int TAG_W = rv_pkg::TAG_W
) (
  input  logic [4:0]                  rs,
  input  logic [NREG-1:0]             busy_q,
  input  logic [NREG-1:0][TAG_W-1:0]  tag_q,
  input  logic [NREG-1:0][XLEN-1:0]   value_q,
`ifdef RF_COMMIT_BYPASS_EN
  input  logic                        rf_valid,
  input  logic [TAG_W-1:0]            rf_index,
  input  logic [4:0]                  rf_rd,
  input  logic [XLEN-1:0]             rf_value,
`endif
  output logic                        busy,
  output logic [TAG_W-1:0]            tag,
  output logic [XLEN-1:0]             value
);

  always_comb begin
    busy  = 1'b0;
    tag   = '0;
    value = '0;
    if (rs != REG_ZERO) begin
      busy  = busy_q[rs];
      tag   = tag_q[rs];
      value = value_q[rs];
`ifdef RF_COMMIT_BYPASS_EN
      // The commit value is always the newest architectural value; the
      // busy bit only drops if the committing tag is the current owner.
      if (rf_valid && rf_rd == rs) begin
        value = rf_value;
        if (tag_q[rs] == rf_index) busy = 1'b0;
      end
`endif
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with rename status.
// Holds value/busy/tag per register; ROB commits write values and release
// ownership, the issue unit renames destinations, flush drops all renames.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset, dominates rdy
//   bus  : register_file_if.slave (control, rename, read, commit)
// Macro: RF_COMMIT_BYPASS_EN enables same-cycle commit forwarding on reads.
module register_file
  import rv_pkg::*;
#(
  parameter int NREG  = rv_pkg::NREG,
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int TAG_W = rv_pkg::TAG_W
) (
  input  logic            clk,
  input  logic            rst,
  register_file_if.slave  bus
);

  localparam int NUM_PORTS = 2;

  logic [NREG-1:0]            busy_q;
  logic [NREG-1:0][TAG_W-1:0] tag_q;
  logic [NREG-1:0][XLEN-1:0]  value_q;

  logic commit_en;
  logic rename_en;

  assign commit_en = bus.rf_valid && (bus.rf_rd != REG_ZERO);
  assign rename_en = bus.issue_valid && (bus.issue_rd != REG_ZERO);

  // x0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      tag_q   <= '0;
      value_q <= '0;
    end else if (bus.rdy) begin
      for (int i = 1; i < NREG; i++) begin
        if (commit_en && bus.rf_rd == 5'(i)) value_q[i] <= bus.rf_value;
        // Status priority: flush, then rename (youngest owner), then release.
        if (bus.flush) begin
          busy_q[i] <= 1'b0;
          tag_q[i]  <= '0;
        end else if (rename_en && bus.issue_rd == 5'(i)) begin
          busy_q[i] <= 1'b1;
          tag_q[i]  <= bus.issue_rob_index;
        end else if (commit_en && bus.rf_rd == 5'(i) &&
                     busy_q[i] && tag_q[i] == bus.rf_index) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  logic [NUM_PORTS-1:0][4:0]       rs_idx;
  logic [NUM_PORTS-1:0]            rd_busy;
  logic [NUM_PORTS-1:0][TAG_W-1:0] rd_tag;
  logic [NUM_PORTS-1:0][XLEN-1:0]  rd_value;

  assign rs_idx[0] = bus.rs1;
  assign rs_idx[1] = bus.rs2;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    rf_read_port #(
      .NREG  (NREG),
      .XLEN  (XLEN),
      .TAG_W (TAG_W)
    ) u_rd (
      .rs       (rs_idx[p]),
      .busy_q   (busy_q),
      .tag_q    (tag_q),
      .value_q  (value_q),
`ifdef RF_COMMIT_BYPASS_EN
      .rf_valid (bus.rf_valid),
      .rf_index (bus.rf_index),
      .rf_rd    (bus.rf_rd),
      .rf_value (bus.rf_value),
`endif
      .busy     (rd_busy[p]),
      .tag      (rd_tag[p]),
      .value    (rd_value[p])
    );
  end

  assign bus.rs1_busy  = rd_busy[0];
  assign bus.rs1_tag   = rd_tag[0];
  assign bus.rs1_value = rd_value[0];
  assign bus.rs2_busy  = rd_busy[1];
  assign bus.rs2_tag   = rd_tag[1];
  assign bus.rs2_value = rd_value[1];

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  register_file_if rif ();

  register_file u_dut (
    .clk (clk),
    .rst (rst),
    .bus (rif.slave)
  );

  // Reference model: plain arrays updated once per clock from the rules.
  logic [31:0] m_val  [32];
  bit          m_busy [32];
  logic [5:0]  m_tag  [32];

  function automatic void model_update();
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_val[r] = '0; m_busy[r] = 0; m_tag[r] = '0;
      end
      return;
    end
    if (!rif.rdy) return;
    if (rif.rf_valid && rif.rf_rd != 0) begin
      m_val[rif.rf_rd] = rif.rf_value;
      if (m_busy[rif.rf_rd] && m_tag[rif.rf_rd] == rif.rf_index)
        m_busy[rif.rf_rd] = 0;
    end
    if (rif.flush) begin
      for (int r = 0; r < 32; r++) begin
        m_busy[r] = 0; m_tag[r] = '0;
      end
    end else if (rif.issue_valid && rif.issue_rd != 0) begin
      m_busy[rif.issue_rd] = 1;
      m_tag[rif.issue_rd]  = rif.issue_rob_index;
    end
  endfunction

  function automatic void exp_rd(input logic [4:0] rs, output logic b,
                                 output logic [5:0] t, output logic [31:0] v);
    b = 0; t = '0; v = '0;
    if (rs != 0) begin
      b = m_busy[rs]; t = m_tag[rs]; v = m_val[rs];
`ifdef RF_COMMIT_BYPASS_EN
      if (rif.rf_valid && rif.rf_rd == rs) begin
        v = rif.rf_value;
        if (m_tag[rs] == rif.rf_index) b = 0;
      end
`endif
    end
  endfunction

  task automatic idle();
    rst = 0;
    rif.rdy = 1; rif.flush = 0;
    rif.issue_valid = 0; rif.issue_rd = '0; rif.issue_rob_index = '0;
    rif.rf_valid = 0; rif.rf_index = '0; rif.rf_rd = '0; rif.rf_value = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    idle();
    #1;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [5:0] t);
    rif.issue_valid = 1; rif.issue_rd = rd; rif.issue_rob_index = t;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [5:0] idx, input logic [31:0] v);
    rif.rf_valid = 1; rif.rf_rd = rd; rif.rf_index = idx; rif.rf_value = v;
  endtask

  task automatic test_reset();
    rename(5'd5, 6'd33); commit(5'd9, 6'd1, 32'h1234);
    tick();
    // Reset with rdy low and traffic on the bus: reset must still win.
    rst = 1; rif.rdy = 0; rename(5'd6, 6'd7); commit(5'd5, 6'd2, 32'hFFFF);
    @(posedge clk); model_update(); @(negedge clk); idle(); #1;
    rif.rs1 = 5'd5; rif.rs2 = 5'd0; #1;
    checks++;
    if ({rif.rs1_busy, rif.rs1_tag, rif.rs1_value} !== '0) begin
      failures++; $display("FAIL reset_rs1 got busy=%0b tag=%0d val=%h want 0", rif.rs1_busy, rif.rs1_tag, rif.rs1_value);
    end
    checks++;
    if ({rif.rs2_busy, rif.rs2_tag, rif.rs2_value} !== '0) begin
      failures++; $display("FAIL reset_rs2 got busy=%0b tag=%0d val=%h want 0", rif.rs2_busy, rif.rs2_tag, rif.rs2_value);
    end
    rif.rs1 = 5'd9; #1;
    checks++;
    if (rif.rs1_value !== 32'h0) begin
      failures++; $display("FAIL reset_x9 got val=%h want 0", rif.rs1_value);
    end
  endtask

  task automatic test_commit();
    rename(5'd5, 6'd12); tick();
    rif.rs1 = 5'd5; #1;
    checks++;
    if (rif.rs1_busy !== 1'b1 || rif.rs1_tag !== 6'd12) begin
      failures++; $display("FAIL rename_x5 got busy=%0b tag=%0d want 1/12", rif.rs1_busy, rif.rs1_tag);
    end
    commit(5'd5, 6'd12, 32'hDEADBEEF); tick();
    rif.rs1 = 5'd5; #1;
    checks++;
    if (rif.rs1_busy !== 1'b0 || rif.rs1_value !== 32'hDEADBEEF) begin
      failures++; $display("FAIL commit_x5 got busy=%0b val=%h want 0/deadbeef", rif.rs1_busy, rif.rs1_value);
    end
  endtask

  task automatic test_younger_rename();
    rename(5'd7, 6'd3); tick();
    rename(5'd7, 6'd9); tick();
    commit(5'd7, 6'd3, 32'h11); tick();
    rif.rs2 = 5'd7; #1;
    checks++;
    if (rif.rs2_busy !== 1'b1 || rif.rs2_tag !== 6'd9 || rif.rs2_value !== 32'h11) begin
      failures++; $display("FAIL stale_commit_x7 got busy=%0b tag=%0d val=%h want 1/9/11", rif.rs2_busy, rif.rs2_tag, rif.rs2_value);
    end
  endtask

  task automatic test_same_cycle();
    logic eb; logic [5:0] et; logic [31:0] ev;
    rename(5'd4, 6'd2); tick();
    commit(5'd4, 6'd2, 32'h55); rename(5'd4, 6'd20);
    rif.rs1 = 5'd4; #1;
    // Reader sees state before this cycle's rename (plus bypass if built).
    exp_rd(5'd4, eb, et, ev);
    checks++;
    if (rif.rs1_busy !== eb || rif.rs1_tag !== et || rif.rs1_value !== ev) begin
      failures++; $display("FAIL pre_rename_read_x4 got %0b/%0d/%h want %0b/%0d/%h", rif.rs1_busy, rif.rs1_tag, rif.rs1_value, eb, et, ev);
    end
    tick();
    rif.rs1 = 5'd4; #1;
    checks++;
    if (rif.rs1_busy !== 1'b1 || rif.rs1_tag !== 6'd20 || rif.rs1_value !== 32'h55) begin
      failures++; $display("FAIL commit_rename_x4 got %0b/%0d/%h want 1/20/55", rif.rs1_busy, rif.rs1_tag, rif.rs1_value);
    end
  endtask

  task automatic test_flush();
    rename(5'd1, 6'd1); tick();
    rename(5'd2, 6'd2); tick();
    rif.flush = 1; commit(5'd3, 6'd40, 32'h77); rename(5'd6, 6'd5); tick();
    rif.rs1 = 5'd1; rif.rs2 = 5'd2; #1;
    checks++;
    if (rif.rs1_busy !== 1'b0 || rif.rs2_busy !== 1'b0 || rif.rs1_tag !== 6'd0 || rif.rs2_tag !== 6'd0) begin
      failures++; $display("FAIL flush_x1_x2 got busy=%0b/%0b tag=%0d/%0d want 0", rif.rs1_busy, rif.rs2_busy, rif.rs1_tag, rif.rs2_tag);
    end
    rif.rs1 = 5'd6; rif.rs2 = 5'd3; #1;
    checks++;
    if (rif.rs1_busy !== 1'b0 || rif.rs2_value !== 32'h77) begin
      failures++; $display("FAIL flush_x6_x3 got busy=%0b val=%h want 0/77", rif.rs1_busy, rif.rs2_value);
    end
  endtask

  task automatic test_rdy_low();
    rename(5'd10, 6'd17); tick();
    rif.rdy = 0; rif.flush = 1; commit(5'd10, 6'd17, 32'hCAFE); rename(5'd11, 6'd8);
    @(posedge clk); model_update(); @(negedge clk); idle();
    rif.rs1 = 5'd10; rif.rs2 = 5'd11; #1;
    checks++;
    if (rif.rs1_busy !== 1'b1 || rif.rs1_tag !== 6'd17 || rif.rs1_value === 32'hCAFE || rif.rs2_busy !== 1'b0) begin
      failures++; $display("FAIL rdy_low_hold got x10 %0b/%0d/%h x11 busy=%0b want 1/17/old, 0", rif.rs1_busy, rif.rs1_tag, rif.rs1_value, rif.rs2_busy);
    end
  endtask

  task automatic test_bypass();
    rename(5'd8, 6'd4); tick();
    commit(5'd8, 6'd4, 32'hA5); rif.rs1 = 5'd8; #1;
`ifdef RF_COMMIT_BYPASS_EN
    checks++;
    if (rif.rs1_busy !== 1'b0 || rif.rs1_value !== 32'hA5) begin
      failures++; $display("FAIL bypass_x8 got busy=%0b val=%h want 0/a5", rif.rs1_busy, rif.rs1_value);
    end
`else
    checks++;
    if (rif.rs1_busy !== 1'b1 || rif.rs1_tag !== 6'd4) begin
      failures++; $display("FAIL nobypass_x8 got busy=%0b tag=%0d want 1/4", rif.rs1_busy, rif.rs1_tag);
    end
`endif
    tick();
    // x0 ignores commit and rename, with or without bypass.
    commit(5'd0, 6'd1, 32'hFFFF_FFFF); rename(5'd0, 6'd1); rif.rs2 = 5'd0; #1;
    checks++;
    if ({rif.rs2_busy, rif.rs2_tag, rif.rs2_value} !== '0) begin
      failures++; $display("FAIL x0_same_cycle got %0b/%0d/%h want 0", rif.rs2_busy, rif.rs2_tag, rif.rs2_value);
    end
    tick();
    rif.rs2 = 5'd0; #1;
    checks++;
    if ({rif.rs2_busy, rif.rs2_tag, rif.rs2_value} !== '0) begin
      failures++; $display("FAIL x0_after got %0b/%0d/%h want 0", rif.rs2_busy, rif.rs2_tag, rif.rs2_value);
    end
  endtask

  task automatic test_random();
    logic eb; logic [5:0] et; logic [31:0] ev;
    for (int n = 0; n < 400; n++) begin
      rif.rdy         = ($urandom_range(9) != 0);
      rif.flush       = ($urandom_range(24) == 0);
      rif.issue_valid = $urandom_range(1);
      rif.issue_rd    = 5'($urandom_range(7));
      rif.issue_rob_index = 6'($urandom);
      rif.rf_valid    = $urandom_range(1);
      rif.rf_rd       = 5'($urandom_range(7));
      rif.rf_index    = $urandom_range(1) ? m_tag[rif.rf_rd] : 6'($urandom);
      rif.rf_value    = $urandom;
      rif.rs1         = $urandom_range(1) ? rif.rf_rd : 5'($urandom_range(7));
      rif.rs2         = 5'($urandom_range(7));
      #1;
      exp_rd(rif.rs1, eb, et, ev);
      checks++;
      if (rif.rs1_busy !== eb || (eb && rif.rs1_tag !== et) || (!eb && rif.rs1_value !== ev)) begin
        failures++; $display("FAIL rand_rs1 n=%0d x%0d got %0b/%0d/%h want %0b/%0d/%h", n, rif.rs1, rif.rs1_busy, rif.rs1_tag, rif.rs1_value, eb, et, ev);
      end
      exp_rd(rif.rs2, eb, et, ev);
      checks++;
      if (rif.rs2_busy !== eb || rif.rs2_tag !== et || rif.rs2_value !== ev) begin
        failures++; $display("FAIL rand_rs2 n=%0d x%0d got %0b/%0d/%h want %0b/%0d/%h", n, rif.rs2, rif.rs2_busy, rif.rs2_tag, rif.rs2_value, eb, et, ev);
      end
      tick();
    end
  endtask

  initial begin
    idle();
    rst = 1; rif.rs1 = '0; rif.rs2 = '0;
    for (int r = 0; r < 32; r++) begin
      m_val[r] = '0; m_busy[r] = 0; m_tag[r] = '0;
    end
    @(negedge clk);
    rst = 1;
    @(posedge clk); model_update(); @(negedge clk); idle(); #1;
    test_reset();
    test_commit();
    test_younger_rename();
    test_same_cycle();
    test_flush();
    test_rdy_low();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
